// File: rtl/bs_capture_seq.sv
// Bandscope capture sequencer: generates RAM write strobes and addresses for up to CHANNELS
// raw-sample buffers, filled round-robin with decimation, period timing and a ready/ack handshake.
module bs_capture_seq #(
  parameter int ADDR_W   = 14,
  parameter int CHANNELS = 2,
  parameter int PERIOD_W = 8,
  parameter int DEC_W    = 4,
  parameter int PRESCALE = 122880,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clock,
  input  logic                   m_reset,
  input  logic                   enable,
  input  logic                   single,
  input  logic                   arm,
  input  logic [CHANNELS-1:0]    chan_mask,
  input  logic [PERIOD_W-1:0]    period,
  input  logic [DEC_W-1:0]       decim,
  input  logic                   clip,
  input  logic                   ack,
  output logic                   wr_en,
  output logic [CH_W+ADDR_W-1:0] wr_addr,
  output logic [CH_W-1:0]        chan,
  output logic                   ready,
  output logic                   clip_flag,
  output logic                   busy
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [ADDR_W-1:0] OFS_LAST = '1;

  typedef enum logic [1:0] {IDLE, FILL, READY, WAIT} state_t;

  state_t                 state_reg;
  logic [ADDR_W-1:0]      offset_reg;
  logic [DEC_W-1:0]       dec_cnt_reg;
  logic [DEC_W-1:0]       decim_reg;
  logic [CHANNELS-1:0]    mask_reg;
  logic [PERIOD_W-1:0]    period_reg;
  logic [PERIOD_W-1:0]    tick_reg;
  logic [PS_W-1:0]        pre_reg;
  logic                   wr_en_reg;
  logic [CH_W+ADDR_W-1:0] wr_addr_reg;
  logic [CH_W-1:0]        chan_reg;
  logic                   ready_reg;
  logic                   clip_flag_reg;
  logic                   busy_reg;

  logic [CHANNELS-1:0]    higher_mask;
  logic [ADDR_W-1:0]      offset_next;
  logic                   wait_done;
  logic                   enter_fill;
  logic [CH_W-1:0]        fill_ch;

  function automatic logic [CH_W-1:0] lowest_bit(input logic [CHANNELS-1:0] m);
    lowest_bit = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = CH_W'(i);
    end
  endfunction

  // Channels of the latched round that come after the current one.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_higher
    assign higher_mask[gi] = mask_reg[gi] && (CH_W'(gi) > chan_reg);
  end

  assign offset_next = offset_reg + ADDR_W'(wr_en_reg);
  assign wait_done   = (period_reg == '0) ||
                       ((pre_reg == PS_LAST) && (tick_reg == period_reg - PERIOD_W'(1)));

  always_comb begin
    enter_fill = 1'b0;
    fill_ch    = lowest_bit(chan_mask);
    case (state_reg)
      IDLE:  enter_fill = enable && (chan_mask != '0) && (!single || arm);
      READY: begin
        if (ack && (higher_mask != '0)) begin
          enter_fill = 1'b1;
          fill_ch    = lowest_bit(higher_mask);
        end
      end
      WAIT:  enter_fill = wait_done && (chan_mask != '0);
      default: enter_fill = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge m_reset) begin
    if (!m_reset) begin
      state_reg     <= IDLE;
      offset_reg    <= '0;
      dec_cnt_reg   <= '0;
      decim_reg     <= '0;
      mask_reg      <= '0;
      period_reg    <= '0;
      tick_reg      <= '0;
      pre_reg       <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      chan_reg      <= '0;
      ready_reg     <= 1'b0;
      clip_flag_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (!enable) begin
      // chan and clip_flag deliberately survive so the reader can still inspect them
      state_reg   <= IDLE;
      offset_reg  <= '0;
      dec_cnt_reg <= '0;
      tick_reg    <= '0;
      pre_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else if (enter_fill) begin
      state_reg     <= FILL;
      offset_reg    <= '0;
      dec_cnt_reg   <= '0;
      decim_reg     <= decim;
      mask_reg      <= chan_mask;
      wr_en_reg     <= 1'b1;
      wr_addr_reg   <= {fill_ch, {ADDR_W{1'b0}}};
      chan_reg      <= fill_ch;
      ready_reg     <= 1'b0;
      clip_flag_reg <= 1'b0;
      busy_reg      <= 1'b1;
    end else begin
      case (state_reg)
        FILL: begin
          if (clip) clip_flag_reg <= 1'b1;
          if (wr_en_reg && (offset_reg == OFS_LAST)) begin
            state_reg   <= READY;
            offset_reg  <= '0;
            dec_cnt_reg <= '0;
            wr_en_reg   <= 1'b0;
            ready_reg   <= 1'b1;
          end else begin
            offset_reg <= offset_next;
            // dec_cnt counts clocks since the last strobe
            if (dec_cnt_reg == decim_reg) begin
              wr_en_reg   <= 1'b1;
              dec_cnt_reg <= '0;
              wr_addr_reg <= {chan_reg, offset_next};
            end else begin
              wr_en_reg   <= 1'b0;
              dec_cnt_reg <= dec_cnt_reg + DEC_W'(1);
            end
          end
        end
        READY: begin
          if (ack) begin
            ready_reg <= 1'b0;
            if (single) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg  <= WAIT;
              period_reg <= period;
              tick_reg   <= '0;
              pre_reg    <= '0;
            end
          end
        end
        WAIT: begin
          if (wait_done) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (pre_reg == PS_LAST) begin
            pre_reg  <= '0;
            tick_reg <= tick_reg + PERIOD_W'(1);
          end else begin
            pre_reg <= pre_reg + PS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign chan      = chan_reg;
  assign ready     = ready_reg;
  assign clip_flag = clip_flag_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_bs_capture_seq.sv
// Directed bench for bs_capture_seq with 8-sample buffers, two channels and a 4-clock tick.
module tb_bs_capture_seq;
  localparam int ADDR_W   = 3;
  localparam int CHANNELS = 2;
  localparam int PERIOD_W = 8;
  localparam int DEC_W    = 4;
  localparam int PRESCALE = 4;

  logic       clock = 1'b0;
  logic       m_reset = 1'b0;
  logic       enable = 1'b0;
  logic       single = 1'b0;
  logic       arm = 1'b0;
  logic       clip = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] chan_mask = 2'b00;
  logic [7:0] period = 8'd0;
  logic [3:0] decim = 4'd0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic       chan;
  logic       ready;
  logic       clip_flag;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  bs_capture_seq #(
    .ADDR_W(ADDR_W), .CHANNELS(CHANNELS), .PERIOD_W(PERIOD_W),
    .DEC_W(DEC_W), .PRESCALE(PRESCALE)
  ) dut (
    .clock(clock), .m_reset(m_reset), .enable(enable), .single(single), .arm(arm),
    .chan_mask(chan_mask), .period(period), .decim(decim), .clip(clip), .ack(ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .chan(chan), .ready(ready),
    .clip_flag(clip_flag), .busy(busy)
  );

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic test_reset();
    m_reset = 1'b0;
    repeat (2) next_cycle();
    tests++;
    if ({wr_en, wr_addr, chan, ready, clip_flag, busy} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want %b", {wr_en, wr_addr, chan, ready, clip_flag, busy}, 9'd0);
    end
    m_reset = 1'b1;
    next_cycle();
    tests++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b wr_en=%b want 0 0", busy, wr_en);
    end
    $display("[TB] test_reset complete");
  endtask

  task automatic test_continuous();
    chan_mask = 2'b01; decim = 4'd0; single = 1'b0; period = 8'd0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(i) || busy !== 1'b1 || ready !== 1'b0) begin
        fails++;
        $display("FAIL cont_strobe[%0d]: wr_en=%b addr=%0d busy=%b ready=%b want 1 %0d 1 0", i, wr_en, wr_addr, busy, ready, i);
      end
    end
    next_cycle();
    tests++;
    if (wr_en !== 1'b0 || ready !== 1'b1 || chan !== 1'b0) begin
      fails++;
      $display("FAIL cont_ready: wr_en=%b ready=%b chan=%b want 0 1 0", wr_en, ready, chan);
    end
    repeat (3) next_cycle();
    tests++;
    if (wr_en !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL cont_ready_hold: wr_en=%b ready=%b want 0 1", wr_en, ready);
    end
    enable = 1'b0;
    next_cycle();
    tests++;
    if (wr_en !== 1'b0 || ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL cont_disable: wr_en=%b ready=%b busy=%b want 0 0 0", wr_en, ready, busy);
    end
    $display("[TB] test_continuous complete");
  endtask

  task automatic test_two_channel();
    chan_mask = 2'b11; decim = 4'd2; single = 1'b0; period = 8'd3; enable = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      for (int c = 0; c < 22; c++) begin
        next_cycle();
        ack = 1'b0;
        tests++;
        if (wr_en !== (c % 3 == 0) || chan !== 1'(ch) ||
            ((c % 3 == 0) && wr_addr !== 4'(ch * 8 + c / 3))) begin
          fails++;
          $display("FAIL dec_strobe ch%0d c%0d: wr_en=%b addr=%0d chan=%b want %b %0d %0d",
                   ch, c, wr_en, wr_addr, chan, (c % 3 == 0), ch * 8 + c / 3, ch);
        end
      end
      next_cycle();
      tests++;
      if (ready !== 1'b1 || wr_en !== 1'b0 || chan !== 1'(ch)) begin
        fails++;
        $display("FAIL dec_ready ch%0d: ready=%b wr_en=%b chan=%b want 1 0 %0d", ch, ready, wr_en, chan, ch);
      end
      $display("[TB] buffer ch%0d ready, ack sent", ch);
      ack = 1'b1;
    end
    // After the second ack: twelve WAIT cycles, then a new round on channel 0
    for (int k = 1; k <= 13; k++) begin
      next_cycle();
      ack = 1'b0;
      if (k == 1) period = 8'd7;
      tests++;
      if (k < 13) begin
        if (wr_en !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
          fails++;
          $display("FAIL wait_cycle[%0d]: wr_en=%b busy=%b ready=%b want 0 1 0", k, wr_en, busy, ready);
        end
      end else begin
        if (wr_en !== 1'b1 || chan !== 1'b0 || wr_addr !== 4'd0) begin
          fails++;
          $display("FAIL wait_refill: wr_en=%b chan=%b addr=%0d want 1 0 0", wr_en, chan, wr_addr);
        end
      end
    end
    enable = 1'b0;
    next_cycle();
    tests++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL two_ch_disable: busy=%b wr_en=%b want 0 0", busy, wr_en);
    end
    $display("[TB] test_two_channel complete");
  endtask

  task automatic test_single_shot();
    single = 1'b1; chan_mask = 2'b01; decim = 4'd0; period = 8'd0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tests++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
        fails++;
        $display("FAIL single_no_arm[%0d]: busy=%b wr_en=%b want 0 0", i, busy, wr_en);
      end
    end
    arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      arm = (i == 2);
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(i) || busy !== 1'b1) begin
        fails++;
        $display("FAIL single_strobe[%0d]: wr_en=%b addr=%0d busy=%b want 1 %0d 1", i, wr_en, wr_addr, busy, i);
      end
    end
    arm = 1'b0;
    next_cycle();
    tests++;
    if (ready !== 1'b1 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL single_ready: ready=%b wr_en=%b want 1 0", ready, wr_en);
    end
    ack = 1'b1;
    next_cycle();
    ack = 1'b0;
    tests++;
    if (ready !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL single_done: ready=%b busy=%b wr_en=%b want 0 0 0", ready, busy, wr_en);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      tests++;
      if (wr_en !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL single_stay_idle[%0d]: wr_en=%b busy=%b want 0 0", i, wr_en, busy);
      end
    end
    $display("[TB] test_single_shot complete");
  endtask

  task automatic test_clip();
    single = 1'b1; chan_mask = 2'b11; decim = 4'd0; enable = 1'b1;
    arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      arm = 1'b0;
      clip = (i == 5);
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(i) || chan !== 1'b0) begin
        fails++;
        $display("FAIL clip_fill0[%0d]: wr_en=%b addr=%0d chan=%b want 1 %0d 0", i, wr_en, wr_addr, chan, i);
      end
    end
    next_cycle();
    clip = 1'b0;
    tests++;
    if (ready !== 1'b1 || clip_flag !== 1'b1) begin
      fails++;
      $display("FAIL clip_set: ready=%b clip_flag=%b want 1 1", ready, clip_flag);
    end
    ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      ack = 1'b0;
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(8 + i) || clip_flag !== 1'b0) begin
        fails++;
        $display("FAIL clip_fill1[%0d]: wr_en=%b addr=%0d clip_flag=%b want 1 %0d 0", i, wr_en, wr_addr, clip_flag, 8 + i);
      end
    end
    next_cycle();
    tests++;
    if (ready !== 1'b1 || chan !== 1'b1 || clip_flag !== 1'b0) begin
      fails++;
      $display("FAIL clip_clear: ready=%b chan=%b clip_flag=%b want 1 1 0", ready, chan, clip_flag);
    end
    clip = 1'b1;
    next_cycle();
    clip = 1'b0;
    next_cycle();
    tests++;
    if (clip_flag !== 1'b0) begin
      fails++;
      $display("FAIL clip_ignored_ready: clip_flag=%b want 0", clip_flag);
    end
    ack = 1'b1;
    next_cycle();
    ack = 1'b0;
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0 || chan !== 1'b1) begin
      fails++;
      $display("FAIL clip_round_end: busy=%b ready=%b chan=%b want 0 0 1", busy, ready, chan);
    end
    $display("[TB] test_clip complete");
  endtask

  task automatic test_enable_fall();
    single = 1'b0; chan_mask = 2'b01; decim = 4'd0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(i)) begin
        fails++;
        $display("FAIL en_strobe[%0d]: wr_en=%b addr=%0d want 1 %0d", i, wr_en, wr_addr, i);
      end
    end
    enable = 1'b0;
    next_cycle();
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL en_fall_fill: wr_en=%b busy=%b ready=%b want 0 0 0", wr_en, busy, ready);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tests++;
      if (wr_en !== 1'b0) begin
        fails++;
        $display("FAIL en_fall_quiet[%0d]: wr_en=%b want 0", i, wr_en);
      end
    end
    chan_mask = 2'b11; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(i)) begin
        fails++;
        $display("FAIL en_restart[%0d]: wr_en=%b addr=%0d want 1 %0d", i, wr_en, wr_addr, i);
      end
    end
    next_cycle();
    tests++;
    if (ready !== 1'b1 || chan !== 1'b0) begin
      fails++;
      $display("FAIL en_ready: ready=%b chan=%b want 1 0", ready, chan);
    end
    ack = 1'b1; enable = 1'b0;
    next_cycle();
    ack = 1'b0;
    tests++;
    if (ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || chan !== 1'b0) begin
      fails++;
      $display("FAIL ack_enable_fall: ready=%b wr_en=%b busy=%b chan=%b want 0 0 0 0", ready, wr_en, busy, chan);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tests++;
      if (wr_en !== 1'b0) begin
        fails++;
        $display("FAIL ack_enable_quiet[%0d]: wr_en=%b want 0", i, wr_en);
      end
    end
    $display("[TB] test_enable_fall complete");
  endtask

  task automatic test_async_reset();
    single = 1'b0; chan_mask = 2'b01; decim = 4'd0; enable = 1'b1;
    repeat (3) next_cycle();
    #2 m_reset = 1'b0;
    #1;
    tests++;
    if ({wr_en, wr_addr, chan, ready, clip_flag, busy} !== 9'd0) begin
      fails++;
      $display("FAIL async_reset: got %b want %b", {wr_en, wr_addr, chan, ready, clip_flag, busy}, 9'd0);
    end
    next_cycle();
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_hold: wr_en=%b busy=%b want 0 0", wr_en, busy);
    end
    enable = 1'b0;
    m_reset = 1'b1;
    next_cycle();
    $display("[TB] test_async_reset complete");
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_two_channel();
    test_single_shot();
    test_clip();
    test_enable_fall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
